// File: rtl/seq_alu_mc_if.sv
// Operation/result handshake bundle between the decode stage, the multi-cycle ALU and writeback.
// The master drives operands and out_ready; the slave (the ALU) returns in_ready, result and flags.
interface seq_alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inp1;
  logic [WIDTH-1:0] inp2;
  logic [1:0]       opcode;
  logic [3:0]       fcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] high;
  logic             carryFlag;
  logic             zFlag;
  logic             signFlag;
  logic             overflowFlag;
  logic             illegal;

  modport master (
    output in_valid, inp1, inp2, opcode, fcode, out_ready,
    input  in_ready, out_valid, out, high, carryFlag, zFlag, signFlag, overflowFlag, illegal
  );

  modport slave (
    input  in_valid, inp1, inp2, opcode, fcode, out_ready,
    output in_ready, out_valid, out, high, carryFlag, zFlag, signFlag, overflowFlag, illegal
  );
endinterface

// File: rtl/seq_alu_mc.sv
// Multi-cycle KGP-RISC ALU: 1-cycle ops, WIDTH-iteration shift-add multiply; result held in DONE until out_ready.
// SEQ_ALU_MC_EARLY_TERM_EN lets MUL finish once the remaining multiplier bits are zero.
module seq_alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  seq_alu_mc_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_MAX  = CW'(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [WIDTH:0]     ONE_W1   = (WIDTH+1)'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   out_q, high_q;
  logic               c_q, z_q, s_q, v_q, ill_q;

  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic               in_ready, out_valid;

  // decode
  logic             is_illegal, is_smul, is_umul, is_mul;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] a, b;

  assign a          = bus.inp1;
  assign b          = bus.inp2;
  assign sh         = b[SHW-1:0];
  assign is_illegal = (bus.opcode != 2'b00) || (bus.fcode[3:2] == 2'b11);
  assign is_smul    = !is_illegal && (bus.fcode == 4'b0001);
  assign is_umul    = !is_illegal && (bus.fcode == 4'b0010);
  assign is_mul     = is_smul || is_umul;

  // single-cycle datapath
  logic [WIDTH-1:0] res, res_fin;
  logic             res_c, res_v;

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (bus.fcode)
      4'b0000: begin
        {res_c, res} = {1'b0, a} + {1'b0, b};
        res_v        = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0011:          {res_c, res} = {1'b0, ~b} + ONE_W1;
      4'b0100:          res = a & b;
      4'b0101:          res = a ^ b;
      4'b0110, 4'b1000: res = a << sh;
      4'b0111, 4'b1001: res = a >> sh;
      4'b1010, 4'b1011: res = WIDTH'($signed(a) >>> sh);
      default:          res = '0;
    endcase
  end

  assign res_fin = is_illegal ? '0 : res;

  // multiply operand preparation: iterate on magnitudes, fix the sign at the end
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = is_smul && a[WIDTH-1];
  assign b_neg = is_smul && b[WIDTH-1];
  assign a_mag = a_neg ? (~a + ONE_W) : a;
  assign b_mag = b_neg ? (~b + ONE_W) : b;

  logic [2*WIDTH-1:0] acc_sum, prod_fin;
  logic               mul_last;

  assign acc_sum  = mplier[0] ? (acc + mcand) : acc;
  assign prod_fin = neg ? (~acc_sum + ONE_2W) : acc_sum;

`ifdef SEQ_ALU_MC_EARLY_TERM_EN
  assign mul_last = (cnt == CNT_LAST) || (mplier[WIDTH-1:1] == '0);
`else
  assign mul_last = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = is_mul ? MUL : DONE;
      end
      MUL: begin
        if (mul_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      high_q <= '0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      s_q    <= 1'b0;
      v_q    <= 1'b0;
      ill_q  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_mul) begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              cnt    <= '0;
              neg    <= a_neg ^ b_neg;
            end else begin
              out_q  <= res_fin;
              high_q <= '0;
              c_q    <= !is_illegal && res_c;
              v_q    <= !is_illegal && res_v;
              z_q    <= (res_fin == '0);
              s_q    <= res_fin[WIDTH-1];
              ill_q  <= is_illegal;
            end
          end
        end
        MUL: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
          if (mul_last) begin
            {high_q, out_q} <= prod_fin;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            z_q   <= (prod_fin == '0);
            s_q   <= prod_fin[2*WIDTH-1];
            ill_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out          = out_q;
  assign bus.high         = high_q;
  assign bus.carryFlag    = c_q;
  assign bus.zFlag        = z_q;
  assign bus.signFlag     = s_q;
  assign bus.overflowFlag = v_q;
  assign bus.illegal      = ill_q;

endmodule

// File: tb/tb_seq_alu_mc.sv
// Directed vector bench for seq_alu_mc: table of ops with hand-computed results plus
// back-pressure and mid-multiply reset sequences.
module tb_seq_alu_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_alu_mc_if #(.WIDTH(32)) bus ();

  seq_alu_mc #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  fc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_out;
    logic [31:0] e_high;
    logic        e_c, e_z, e_s, e_v, e_ill;
  } vec_t;

  vec_t tv[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mkv(logic [1:0] op, logic [3:0] fc, logic [31:0] a, logic [31:0] b,
                               logic [31:0] e_out, logic [31:0] e_high,
                               logic c, logic z, logic s, logic v, logic ill);
    vec_t r;
    r.op = op; r.fc = fc; r.a = a; r.b = b; r.e_out = e_out; r.e_high = e_high;
    r.e_c = c; r.e_z = z; r.e_s = s; r.e_v = v; r.e_ill = ill;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // reference latency: 1 for single-cycle ops, multiply latency depends on build
  function automatic int exp_lat(vec_t v);
    logic [31:0] m;
    int          hb;
    if (v.op != 2'b00 || !(v.fc == 4'b0001 || v.fc == 4'b0010)) return 1;
    m  = (v.fc == 4'b0001 && v.b[31]) ? (~v.b + 32'd1) : v.b;
    hb = -1;
    for (int i = 0; i < 32; i++) if (m[i]) hb = i;
`ifdef SEQ_ALU_MC_EARLY_TERM_EN
    return (hb < 0) ? 2 : hb + 2;
`else
    return 33;
`endif
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    bit busy_seen;
    bus.inp1      = v.a;
    bus.inp2      = v.b;
    bus.opcode    = v.op;
    bus.fcode     = v.fc;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat       = 1;
    busy_seen = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) busy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat(v)));
    chk({tag, " out"}, 64'(bus.out), 64'(v.e_out));
    chk({tag, " high"}, 64'(bus.high), 64'(v.e_high));
    chk({tag, " flags c/z/s/v/ill"},
        64'({bus.carryFlag, bus.zFlag, bus.signFlag, bus.overflowFlag, bus.illegal}),
        64'({v.e_c, v.e_z, v.e_s, v.e_v, v.e_ill}));
    chk({tag, " in_ready while busy"}, 64'({busy_seen, bus.in_ready}), 64'(0));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " release out_valid/in_ready"}, 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bit saw_valid;
    //      op     fc     a             b             out           high          c z s v ill
    tv.push_back(mkv(2'b00, 4'h0, 32'hFFFFFFFB, 32'h00000004, 32'hFFFFFFFF, 32'h00000000, 0,0,1,0,0));
    tv.push_back(mkv(2'b00, 4'h1, 32'hFFFFFFFB, 32'h00000004, 32'hFFFFFFEC, 32'hFFFFFFFF, 0,0,1,0,0));
    tv.push_back(mkv(2'b00, 4'h2, 32'hFFFFFFFB, 32'h00000004, 32'hFFFFFFEC, 32'h00000003, 0,0,0,0,0));
    tv.push_back(mkv(2'b00, 4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h00000000, 0,0,1,1,0));
    tv.push_back(mkv(2'b00, 4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1,1,0,0,0));
    tv.push_back(mkv(2'b00, 4'h3, 32'h00001234, 32'h00000004, 32'hFFFFFFFC, 32'h00000000, 0,0,1,0,0));
    tv.push_back(mkv(2'b00, 4'h3, 32'h00001234, 32'h00000000, 32'h00000000, 32'h00000000, 1,1,0,0,0));
    tv.push_back(mkv(2'b00, 4'h4, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 32'h00000000, 0,0,0,0,0));
    tv.push_back(mkv(2'b00, 4'h5, 32'h00000005, 32'h00000004, 32'h00000001, 32'h00000000, 0,0,0,0,0));
    tv.push_back(mkv(2'b00, 4'h6, 32'h00000001, 32'h0000001F, 32'h80000000, 32'h00000000, 0,0,1,0,0));
    tv.push_back(mkv(2'b00, 4'h8, 32'h000000FF, 32'h00000024, 32'h00000FF0, 32'h00000000, 0,0,0,0,0));
    tv.push_back(mkv(2'b00, 4'h7, 32'h80000000, 32'h00000004, 32'h08000000, 32'h00000000, 0,0,0,0,0));
    tv.push_back(mkv(2'b00, 4'h9, 32'hF0000000, 32'h0000001C, 32'h0000000F, 32'h00000000, 0,0,0,0,0));
    tv.push_back(mkv(2'b00, 4'hA, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h00000000, 0,0,1,0,0));
    tv.push_back(mkv(2'b00, 4'hB, 32'h70000000, 32'h00000001, 32'h38000000, 32'h00000000, 0,0,0,0,0));
    tv.push_back(mkv(2'b00, 4'h1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0,0,0,0,0));
    tv.push_back(mkv(2'b00, 4'h1, 32'h00000003, 32'hFFFFFFF9, 32'hFFFFFFEB, 32'hFFFFFFFF, 0,0,1,0,0));
    tv.push_back(mkv(2'b00, 4'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0,0,1,0,0));
    tv.push_back(mkv(2'b00, 4'h2, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 0,1,0,0,0));
    tv.push_back(mkv(2'b00, 4'h2, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 0,1,0,0,0));
    tv.push_back(mkv(2'b00, 4'hC, 32'h00000001, 32'h00000002, 32'h00000000, 32'h00000000, 0,1,0,0,1));
    tv.push_back(mkv(2'b01, 4'h0, 32'h00000001, 32'h00000002, 32'h00000000, 32'h00000000, 0,1,0,0,1));
    tv.push_back(mkv(2'b00, 4'h4, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 32'h00000000, 0,1,0,0,0));
    tv.push_back(mkv(2'b00, 4'hB, 32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 32'h00000000, 0,0,1,0,0));

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.inp1      = '0;
    bus.inp2      = '0;
    bus.opcode    = '0;
    bus.fcode     = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready/out_valid", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    chk("reset out/high", {bus.high, bus.out}, 64'(0));
    chk("reset flags", 64'({bus.carryFlag, bus.zFlag, bus.signFlag, bus.overflowFlag, bus.illegal}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tv[i]) run_op(tv[i], $sformatf("vec%0d", i));

    // back-pressure: result must hold while out_ready is low, new requests ignored
    bus.inp1 = 32'd5; bus.inp2 = 32'd4; bus.opcode = 2'b00; bus.fcode = 4'h5;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus.inp1 = 32'd100 + 32'(i); bus.inp2 = 32'd7; bus.fcode = 4'h0;
      bus.in_valid = (i % 2 == 0);
      chk($sformatf("bp hold %0d valid/ready/out", i),
          {30'd0, bus.out_valid, bus.in_ready, bus.out}, {30'd0, 1'b1, 1'b0, 32'd1});
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready/out_valid", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp no queued op", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));

    // reset in the middle of a signed multiply
    bus.inp1 = 32'hFFFFFFFB; bus.inp2 = 32'd4; bus.opcode = 2'b00; bus.fcode = 4'h1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid-mul in_ready low", 64'(bus.in_ready), 64'(0));
    rst = 1'b1;
    #1;
    chk("rst async in_ready/out_valid", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    chk("rst async out/high", {bus.high, bus.out}, 64'(0));
    chk("rst async flags", 64'({bus.carryFlag, bus.zFlag, bus.signFlag, bus.overflowFlag, bus.illegal}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    chk("no out_valid after rst", 64'({saw_valid, bus.in_ready}), 64'(2'b01));

    run_op(tv[13], "post-rst SHRA");
    run_op(tv[21], "post-rst illegal opcode");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_alu_mc.md
Name: seq_alu_mc

Overview:
Parametrised multi-cycle successor to the single-cycle KGP-RISC ALU.
- Same opcode/fcode operation set and flag outputs; datapath width is a parameter.
- Multiplies run on an iterative shift-add engine instead of a combinational multiplier.
- Sits between decode and writeback, using a valid/ready handshake on input and output so the control unit can stall on long operations.

Parameters:
WIDTH, 32, operand/result width; must be a power of two, ≥8
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands/op valid
in_ready  output  1  ALU can accept an operation
inp1  input  WIDTH  operand A
inp2  input  WIDTH  operand B (shift amount in low SHW bits)
opcode  input  2  major opcode; only 2'b00 is legal
fcode  input  4  function code
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
out  output  WIDTH  result (low half for multiplies)
high  output  WIDTH  high half of product; 0 for other ops
carryFlag  output  1  carry out
zFlag  output  1  result zero
signFlag  output  1  result MSB
overflowFlag  output  1  signed overflow
illegal  output  1  unsupported opcode/fcode

Behaviour:
Reset and handshake
- Reset (async, active-high):
  - all outputs 0 except in_ready=1;
  - FSM to IDLE;
  - any in-flight multiply is discarded.
- FSM states: IDLE, MUL, DONE.
- in_ready = (state==IDLE). An operation is accepted on a clk edge with in_valid && in_ready; operands are latched at that edge.
- Non-multiply ops: result computed and registered at the accept edge; IDLE→DONE; out_valid=1 in the following cycle (latency 1).
- Multiply ops: IDLE→MUL; WIDTH iteration cycles; MUL→DONE on the last iteration; out_valid after edge WIDTH+1 counted from accept.
- DONE: out, high, flags and illegal held stable while out_valid && !out_ready. DONE→IDLE on the edge with out_ready=1, which clears out_valid.
- in_valid is ignored outside IDLE; no queueing.

Operations (opcode 2'b00)
- fcode 0000 ADD: out = inp1+inp2.
  - carryFlag = carry out of bit WIDTH-1.
  - overflowFlag = operand signs equal and result sign differs.
- 0001 SMUL: signed {high,out}.
  - Iterate on magnitudes; negate the 2*WIDTH product at completion if operand signs differ.
- 0010 UMUL: unsigned {high,out}.
- 0011 COMP: out = ~inp2+1; carryFlag = carry out of that add (1 only for inp2=0).
- 0100 AND; 0101 XOR.
- 0110 SHLL / 1000 SHLLV: out = inp1 << inp2[SHW-1:0].
- 0111 SHRL / 1001 SHRLV: logical right shift by inp2[SHW-1:0].
- 1010 SHRA / 1011 SHRAV: arithmetic right shift by inp2[SHW-1:0].
- Immediate and variable shift encodings decode identically; the decoder places the immediate in inp2.

Flags
- zFlag:
  - non-multiply ops: out==0;
  - multiplies: {high,out}==0.
- signFlag:
  - non-multiply ops: out[WIDTH-1];
  - multiplies: high[WIDTH-1].
- carryFlag and overflowFlag are 0 for every op except ADD, plus carryFlag on COMP.
- Illegal (opcode≠00 or fcode 11xx):
  - takes the 1-cycle path;
  - out=high=0, zFlag=1, other flags 0, illegal=1.
- Multiply iteration counter is SHW+1 bits and saturates at WIDTH; no wrap.

Optional Feature:
Macro SEQ_ALU_MC_EARLY_TERM_EN.
- Defined: MUL exits to DONE on the first iteration cycle in which the remaining unshifted multiplier bits are all zero. Latency becomes 2 + index of the highest set bit of |multiplier|; a zero multiplier completes in 2 cycles. Results are identical.
- Undefined: fixed WIDTH+1 latency for all multiplies.

Test Plan:
1. ADD inp1=-5, inp2=4 → out=0xFFFFFFFF, high=0, signFlag=1, carryFlag=0, zFlag=0, overflowFlag=0; out_valid high 1 cycle after accept.
2. SMUL -5×4 → high=0xFFFFFFFF, out=0xFFFFFFEC, signFlag=1; without the macro, out_valid exactly 33 cycles after accept; in_ready=0 throughout.
3. UMUL 0xFFFFFFFB×4 → high=0x00000003, out=0xFFFFFFEC. With the macro defined, latency = 4 (highest set bit of the multiplier, bit 2, +2).
4. ADD 0x7FFFFFFF+1 → out=0x80000000, overflowFlag=1, carryFlag=0. ADD 0xFFFFFFFF+1 → out=0, carryFlag=1, zFlag=1. COMP inp2=4 → 0xFFFFFFFC.
5. Back-pressure: XOR 5,4 with out_ready=0 for 5 cycles → out=1 stable, in_ready=0, pulsed in_valid ignored. out_ready=1 → IDLE next cycle, in_ready=1.
6. rst asserted mid-SMUL (iteration 10) → outputs 0 immediately, no out_valid after release. Then SHRA 0x80000000 by 4 → 0xF8000000; opcode=01 → illegal=1, zFlag=1.
